// File: rtl/eth_preprocess_ctrl_pkg.sv
// eth_preprocess_ctrl_pkg: state encoding, header-word indices and ethertypes shared with the parser
package eth_preprocess_ctrl_pkg;
    typedef enum logic [2:0] {
        SKIP_HDRS = 3'd0,
        WORD_2    = 3'd1,
        WORD_3    = 3'd2,
        WORD_4    = 3'd3,
        WAIT_EOP  = 3'd4
    } state_t;
    localparam int IDX_MAC_DA_HI     = 1;
    localparam int IDX_MAC_DASA      = 2;
    localparam int IDX_ETH_IP_VER    = 3;
    localparam int IDX_IP_TTL_PROTO  = 4;
    localparam logic [15:0] ETH_IP  = 16'h0800;
    localparam logic [15:0] ETH_ARP = 16'h0806;
endpackage

// File: rtl/eth_stat_counter.sv
// eth_stat_counter: wrapping event counter with synchronous clear
module eth_stat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (reset) count <= '0;
        else if (inc) count <= count + W'(1);
    end
endmodule

// File: rtl/eth_preprocess_ctrl.sv
// eth_preprocess_ctrl: zero-latency header-word strobes, runt detect and frame length for the rx parser
// Optional stats counters num_pkts/num_runts are built when PREPROC_STATS_EN is defined.
module eth_preprocess_ctrl
    import eth_preprocess_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  word_MAC_DA_HI,
    output logic                  word_MAC_DASA,
    output logic                  word_ETH_IP_VER,
    output logic                  word_IP_TTL_PROTO,
    output logic                  pkt_done,
    output logic                  pkt_runt,
    output logic [LEN_WIDTH-1:0]  pkt_len_words
`ifdef PREPROC_STATS_EN
    ,
    output logic [31:0]           num_pkts,
    output logic [31:0]           num_runts
`endif
);
    state_t               state;
    logic [LEN_WIDTH-1:0] len_q, len_cur;
    logic                 wr, eop, data_unused;

    assign data_unused = ^in_data;

    // Outputs are forced low during reset even though they are combinational.
    always_comb begin
        wr                = in_wr & ~reset;
        eop               = |in_ctrl;
        word_MAC_DA_HI    = wr & (state == SKIP_HDRS) & ~eop;
        word_MAC_DASA     = wr & (state == WORD_2);
        word_ETH_IP_VER   = wr & (state == WORD_3);
        word_IP_TTL_PROTO = wr & (state == WORD_4);
        pkt_runt          = word_MAC_DASA & eop;
        pkt_done          = wr & eop & ((state == WORD_3) | (state == WORD_4) | (state == WAIT_EOP));
        len_cur = (state == SKIP_HDRS) ? LEN_WIDTH'(IDX_MAC_DA_HI) :
                  (state == WORD_2)    ? LEN_WIDTH'(IDX_MAC_DASA) :
                  (state == WORD_3)    ? LEN_WIDTH'(IDX_ETH_IP_VER) :
                  (state == WORD_4)    ? LEN_WIDTH'(IDX_IP_TTL_PROTO) :
                  (&len_q)             ? len_q : len_q + LEN_WIDTH'(1);
        pkt_len_words = (pkt_done | pkt_runt) ? len_cur : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SKIP_HDRS;
            len_q <= '0;
        end else if (in_wr) begin
            len_q <= len_cur;
            case (state)
                SKIP_HDRS: state <= eop ? SKIP_HDRS : WORD_2;
                WORD_2:    state <= eop ? SKIP_HDRS : WORD_3;
                WORD_3:    state <= eop ? SKIP_HDRS : WORD_4;
                WORD_4:    state <= eop ? SKIP_HDRS : WAIT_EOP;
                default:   state <= eop ? SKIP_HDRS : WAIT_EOP;
            endcase
        end
    end

`ifdef PREPROC_STATS_EN
    eth_stat_counter #(.W(32)) u_pkts  (.clk(clk), .reset(reset), .inc(pkt_done), .count(num_pkts));
    eth_stat_counter #(.W(32)) u_runts (.clk(clk), .reset(reset), .inc(pkt_runt), .count(num_runts));
`endif
endmodule

// File: tb/tb_eth_preprocess_ctrl.sv
// tb_eth_preprocess_ctrl: directed self-checking bench for eth_preprocess_ctrl
// Exercises the PREPROC_STATS_EN counters when that macro is defined.
module tb_eth_preprocess_ctrl;
    localparam logic [5:0] Z = 6'b000000, DA = 6'b100000, DS = 6'b010000, EV = 6'b001000;
    localparam logic [5:0] TT = 6'b000100, DN = 6'b000010, RT = 6'b000001;

    logic        clk = 0, reset = 1, in_wr = 0;
    logic [63:0] in_data = '0;
    logic [7:0]  in_ctrl = '0;
    logic        da_hi, dasa, eth_ip, ttl, done, runt;
    logic [11:0] len;
    int          checks = 0, errors = 0, exp_pkts = 0, exp_runts = 0;
`ifdef PREPROC_STATS_EN
    logic [31:0] num_pkts, num_runts;
`endif

    eth_preprocess_ctrl dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
        .word_MAC_DA_HI(da_hi), .word_MAC_DASA(dasa), .word_ETH_IP_VER(eth_ip),
        .word_IP_TTL_PROTO(ttl), .pkt_done(done), .pkt_runt(runt), .pkt_len_words(len)
`ifdef PREPROC_STATS_EN
        , .num_pkts(num_pkts), .num_runts(num_runts)
`endif
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic wr, input logic [7:0] ctrl,
                        input logic [5:0] ef, input logic [11:0] el, input string tag);
        logic [5:0] of;
        @(posedge clk);
        #1;
        reset   = r;
        in_wr   = wr;
        in_ctrl = ctrl;
        in_data = {$urandom, $urandom};
        @(negedge clk);
        of = {da_hi, dasa, eth_ip, ttl, done, runt};
        checks++;
        assert (of === ef) else begin
            errors++;
            $error("FAIL %s flags observed=%b expected=%b", tag, of, ef);
        end
        checks++;
        assert (len === el) else begin
            errors++;
            $error("FAIL %s len observed=%0d expected=%0d", tag, len, el);
        end
        if (r) begin exp_pkts = 0; exp_runts = 0; end
        if (ef[1]) exp_pkts++;
        if (ef[0]) exp_runts++;
    endtask

    // Header word then n data words, EOP on word n, gap idle cycles after every word.
    task automatic pkt(input int n, input int gap, input string tag);
        logic [5:0] f;
        logic [11:0] l;
        for (int i = 0; i <= n; i++) begin
            f = (i == 1) ? DA : (i == 2) ? DS : (i == 3) ? EV : (i == 4) ? TT : Z;
            if (i == n && n == 2) f |= RT;
            if (i == n && n >= 3) f |= DN;
            l = (i == n) ? ((n > 4095) ? 12'd4095 : 12'(n)) : 12'd0;
            step(0, 1, (i == 0) ? 8'hFF : (i == n) ? 8'h01 : 8'h00, f, l, tag);
            for (int g = 0; g < gap; g++) step(0, 0, 8'h01, Z, 0, "gap");
        end
    endtask

    initial begin
        step(1, 0, 8'h00, Z, 0, "rst_idle");
        step(1, 1, 8'h00, Z, 0, "rst_wr");
        step(0, 0, 8'h00, Z, 0, "idle");
        step(0, 1, 8'hFF, Z, 0, "p1_hdr");
        step(0, 1, 8'h00, DA, 0, "p1_w1");
        step(0, 1, 8'h00, DS, 0, "p1_w2");
        step(0, 1, 8'h00, EV, 0, "p1_w3");
        step(0, 1, 8'h00, TT, 0, "p1_w4");
        step(0, 1, 8'h00, Z, 0, "p1_w5");
        step(0, 1, 8'h00, Z, 0, "p1_w6");
        step(0, 1, 8'h00, Z, 0, "p1_w7");
        step(0, 1, 8'h01, DN, 8, "p1_eop");
        step(0, 1, 8'hFF, Z, 0, "runt_hdr");
        step(0, 1, 8'h00, DA, 0, "runt_w1");
        step(0, 1, 8'h80, DS | RT, 2, "runt_eop");
        step(0, 1, 8'hFF, Z, 0, "p3_hdr");
        step(0, 1, 8'h00, DA, 0, "p3_w1");
        step(0, 1, 8'h00, DS, 0, "p3_w2");
        step(0, 1, 8'h01, EV | DN, 3, "p3_eop");
        pkt(8, 3, "gaps");
        pkt(5, 0, "b2b_a");
        pkt(5, 0, "b2b_b");
        pkt(4, 0, "eop_w4");
        pkt(2, 1, "runt2");
        step(0, 1, 8'hFF, Z, 0, "r_hdr");
        step(0, 1, 8'h00, DA, 0, "r_w1");
        step(0, 1, 8'h00, DS, 0, "r_w2");
        for (int i = 3; i <= 9; i++) step(1, 1, 8'h00, Z, 0, "r_held");
        step(0, 1, 8'h01, Z, 0, "r_w10");
        pkt(3, 0, "after_rst");
        pkt(4100, 0, "sat");
`ifdef PREPROC_STATS_EN
        step(0, 0, 8'h00, Z, 0, "st_idle");
        checks++;
        assert (num_pkts === 32'(exp_pkts)) else begin
            errors++;
            $error("FAIL num_pkts observed=%0d expected=%0d", num_pkts, exp_pkts);
        end
        checks++;
        assert (num_runts === 32'(exp_runts)) else begin
            errors++;
            $error("FAIL num_runts observed=%0d expected=%0d", num_runts, exp_runts);
        end
        step(1, 0, 8'h00, Z, 0, "st_rst");
        step(0, 0, 8'h00, Z, 0, "st_after");
        checks++;
        assert (num_pkts === 32'd0 && num_runts === 32'd0) else begin
            errors++;
            $error("FAIL stats_clear observed=%0d/%0d expected=0/0", num_pkts, num_runts);
        end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
